// File: rtl/uart_rx_buffer_if.sv
// Connects the UART receiver and the host to the receive buffer.
// The receiver supplies frames and the host drains the FIFO through the same bundle.
interface uart_rx_buffer_if #(
    parameter int ADDR_W = 4
);
    logic [7:0]      rx_data;
    logic            rx_parity_error;
    logic            rx_stop_error;
    logic            rx_valid;
    logic            rd_en;
    logic            clr_overflow;
    logic [7:0]      rd_data;
    logic            rd_parity_err;
    logic            rd_stop_err;
    logic            empty;
    logic            full;
    logic [ADDR_W:0] count;
    logic            overflow;
    logic [7:0]      drop_count;
    logic [7:0]      err_count;

    modport master (
        output rx_data, rx_parity_error, rx_stop_error, rx_valid, rd_en, clr_overflow,
        input  rd_data, rd_parity_err, rd_stop_err, empty, full, count,
               overflow, drop_count, err_count
    );

    modport slave (
        input  rx_data, rx_parity_error, rx_stop_error, rx_valid, rd_en, clr_overflow,
        output rd_data, rd_parity_err, rd_stop_err, empty, full, count,
               overflow, drop_count, err_count
    );
endinterface

// File: rtl/uart_rx_buffer.sv
// UART receive buffer: synchronises the receiver's frame-valid level, captures one
// frame per rising edge and stores it with its error flags in a first-word-fall-through FIFO.
module uart_rx_buffer #(
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int DROP_ERRORED = 0
) (
    input  logic            clk,
    input  logic            rst,
    uart_rx_buffer_if.slave bus
);
    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = (ADDR_W)'(1);
    localparam bit                DROP_ERR = (DROP_ERRORED != 0);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   edge_q, edge_d;
    logic [ADDR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]        count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic [7:0]             drop_q, drop_d;
    logic [7:0]             err_q, err_d;

    // Entry layout: {parity_err, stop_err, byte}
    logic [9:0]             mem_q [DEPTH];
    logic [9:0]             head;

    logic has_err, capture, keep, is_full, is_empty;
    logic do_wr, do_drop, do_rd;

    always_comb begin
        has_err  = bus.rx_parity_error | bus.rx_stop_error;
        capture  = sync_q[SYNC_STAGES-1] & ~edge_q;
        keep     = capture & ~(DROP_ERR & has_err);
        is_full  = (count_q == FULL_CNT);
        is_empty = (count_q == '0);
        // A pop on the same edge frees the slot, so a full FIFO still accepts the frame.
        do_wr    = keep & (~is_full | bus.rd_en);
        do_drop  = keep & is_full & ~bus.rd_en;
        do_rd    = bus.rd_en & ~is_empty;
    end

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], bus.rx_valid};
        edge_d     = sync_q[SYNC_STAGES-1];
        wr_ptr_d   = do_wr ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d   = do_rd ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d    = count_q;
        if (do_wr && !do_rd) begin
            count_d = count_q + CNT_ONE;
        end else if (!do_wr && do_rd) begin
            count_d = count_q - CNT_ONE;
        end
        // A drop on the same edge as a clear leaves the flag set.
        overflow_d = do_drop ? 1'b1 : (bus.clr_overflow ? 1'b0 : overflow_q);
        drop_d     = do_drop ? sat_inc(drop_q) : drop_q;
        err_d      = (capture && has_err) ? sat_inc(err_q) : err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q     <= '0;
            edge_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
            err_q      <= '0;
        end else begin
            sync_q     <= sync_d;
            edge_q     <= edge_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= {bus.rx_parity_error, bus.rx_stop_error, bus.rx_data};
        end
    end

    assign head              = mem_q[rd_ptr_q];
    assign bus.rd_data       = head[7:0];
    assign bus.rd_parity_err = head[9];
    assign bus.rd_stop_err   = head[8];
    assign bus.empty         = is_empty;
    assign bus.full          = is_full;
    assign bus.count         = count_q;
    assign bus.overflow      = overflow_q;
    assign bus.drop_count    = drop_q;
    assign bus.err_count     = err_q;
endmodule

// File: tb/tb_uart_rx_buffer.sv
// Bench for uart_rx_buffer: two instances (errored frames kept / dropped) share one
// stimulus stream and are checked against a queue-based frame model.
module tb_uart_rx_buffer;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0] rx_data;
    logic       rx_par, rx_stop, rx_valid, rd_en, clr;

    uart_rx_buffer_if #(.ADDR_W(ADDR_W)) bus0 ();
    uart_rx_buffer_if #(.ADDR_W(ADDR_W)) bus1 ();

    assign bus0.rx_data = rx_data;  assign bus1.rx_data = rx_data;
    assign bus0.rx_parity_error = rx_par;  assign bus1.rx_parity_error = rx_par;
    assign bus0.rx_stop_error = rx_stop;  assign bus1.rx_stop_error = rx_stop;
    assign bus0.rx_valid = rx_valid;  assign bus1.rx_valid = rx_valid;
    assign bus0.rd_en = rd_en;  assign bus1.rd_en = rd_en;
    assign bus0.clr_overflow = clr;  assign bus1.clr_overflow = clr;

    uart_rx_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .SYNC_STAGES(2), .DROP_ERRORED(0))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    uart_rx_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .SYNC_STAGES(2), .DROP_ERRORED(1))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int checks = 0;
    int errors = 0;

    // Reference model: one queue of {parity, stop, byte} per instance.
    logic [9:0] mq0[$];
    logic [9:0] mq1[$];
    bit         mov[2];
    int         mdrop[2];
    int         merr[2];
    bit         h1, h2, h3;   // rx_valid as sampled 1, 2 and 3 edges ago

    task automatic model_reset();
        mq0.delete(); mq1.delete();
        for (int d = 0; d < 2; d++) begin mov[d] = 0; mdrop[d] = 0; merr[d] = 0; end
        h1 = 0; h2 = 0; h3 = 0;
    endtask

    // One clock edge: applies the current inputs to the model, returns at the falling edge.
    task automatic tick();
        bit         cap, herr, dropped;
        logic [9:0] ent;
        logic [9:0] q[$];
        int         pre;
        cap  = h2 && !h3;
        herr = rx_par || rx_stop;
        ent  = {rx_par, rx_stop, rx_data};
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (d == 0) q = mq0; else q = mq1;
            pre = q.size();
            dropped = 0;
            if (cap && herr && merr[d] < 255) merr[d]++;
            if (rd_en && pre > 0) void'(q.pop_front());
            if (cap && !(d == 1 && herr)) begin
                if (pre < DEPTH || rd_en) q.push_back(ent);
                else begin
                    dropped = 1;
                    if (mdrop[d] < 255) mdrop[d]++;
                end
            end
            if (dropped) mov[d] = 1; else if (clr) mov[d] = 0;
            if (d == 0) mq0 = q; else mq1 = q;
        end
        h3 = h2; h2 = h1; h1 = rx_valid;
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input bit par, input bit stop,
                              input int hold, input int gap, input bit rd_on_cap);
        rx_data = data; rx_par = par; rx_stop = stop; rx_valid = 1'b1;
        for (int i = 0; i < hold; i++) begin
            rd_en = (i == 2) && rd_on_cap;
            tick();
        end
        rd_en = 1'b0; rx_valid = 1'b0;
        for (int i = 0; i < gap; i++) tick();
    endtask

    task automatic pop();
        rd_en = 1'b1; tick(); rd_en = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (bus0.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b want 1", bus0.empty); end
        checks++; if (bus0.full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b want 0", bus0.full); end
        checks++; if (bus0.count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus0.count); end
        checks++; if (bus0.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b want 0", bus0.overflow); end
        checks++; if (bus0.drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", bus0.drop_count); end
        checks++; if (bus0.err_count !== 8'd0) begin errors++; $display("FAIL reset_err got %0d want 0", bus0.err_count); end
        checks++; if (bus1.empty !== 1'b1) begin errors++; $display("FAIL reset_empty1 got %0b want 1", bus1.empty); end
    endtask

    task automatic test_single_frame();
        rx_data = 8'hA5; rx_par = 0; rx_stop = 0; rx_valid = 1'b1;
        tick();
        checks++; if (bus0.empty !== 1'b1) begin errors++; $display("FAIL lat_edge1 empty got %0b want 1", bus0.empty); end
        tick();
        checks++; if (bus0.empty !== 1'b1) begin errors++; $display("FAIL lat_edge2 empty got %0b want 1", bus0.empty); end
        tick();
        checks++; if (bus0.empty !== 1'b0) begin errors++; $display("FAIL lat_edge3 empty got %0b want 0", bus0.empty); end
        checks++; if (bus0.rd_data !== 8'hA5) begin errors++; $display("FAIL single_data got %02h want a5", bus0.rd_data); end
        repeat (17) tick();
        rx_valid = 1'b0;
        repeat (4) tick();
        checks++; if (bus0.count !== 5'd1 || mq0.size() != 1) begin errors++; $display("FAIL single_count got %0d want 1", bus0.count); end
        pop();
        checks++; if (bus0.empty !== 1'b1 || bus0.count !== 5'd0) begin errors++; $display("FAIL single_pop empty=%0b count=%0d want 1/0", bus0.empty, bus0.count); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) send_frame(8'(i), 0, 0, 3, 2, 0);
        send_frame(8'hFF, 0, 0, 3, 2, 0);
        checks++; if (bus0.full !== 1'b1 || bus0.count !== 5'd16) begin errors++; $display("FAIL ovf_full full=%0b count=%0d want 1/16", bus0.full, bus0.count); end
        checks++; if (bus0.overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b want 1", bus0.overflow); end
        checks++; if (bus0.drop_count !== 8'd1) begin errors++; $display("FAIL ovf_drop got %0d want 1", bus0.drop_count); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (bus0.rd_data !== 8'(i) || {2'b00, bus0.rd_data} !== mq0[0]) begin
                errors++; $display("FAIL ovf_order[%0d] got %02h want %02h", i, bus0.rd_data, i);
            end
            pop();
        end
        checks++; if (bus0.empty !== 1'b1) begin errors++; $display("FAIL ovf_drained empty got %0b want 1", bus0.empty); end
    endtask

    task automatic test_full_rdwr();
        logic [7:0] exp;
        clr = 1'b1; tick(); clr = 1'b0;
        checks++; if (bus0.overflow !== 1'b0) begin errors++; $display("FAIL clr_ovf got %0b want 0", bus0.overflow); end
        for (int i = 0; i < 16; i++) send_frame(8'h40 + 8'(i), 0, 0, 3, 2, 0);
        send_frame(8'h3C, 0, 0, 3, 2, 1);
        checks++; if (bus0.count !== 5'd16 || bus0.overflow !== 1'b0) begin errors++; $display("FAIL fullrw count=%0d ovf=%0b want 16/0", bus0.count, bus0.overflow); end
        send_frame(8'h99, 0, 0, 3, 2, 0);
        checks++; if (bus0.overflow !== 1'b1 || bus0.drop_count !== 8'd2) begin errors++; $display("FAIL forced_drop ovf=%0b drop=%0d want 1/2", bus0.overflow, bus0.drop_count); end
        clr = 1'b1; tick(); clr = 1'b0;
        checks++; if (bus0.overflow !== 1'b0 || bus0.drop_count !== 8'd2) begin errors++; $display("FAIL clr_keeps_drop ovf=%0b drop=%0d want 0/2", bus0.overflow, bus0.drop_count); end
        for (int i = 0; i < 16; i++) begin
            exp = (i < 15) ? 8'h41 + 8'(i) : 8'h3C;
            checks++; if (bus0.rd_data !== exp) begin errors++; $display("FAIL fullrw_order[%0d] got %02h want %02h", i, bus0.rd_data, exp); end
            pop();
        end
    endtask

    task automatic test_drop_errored();
        send_frame(8'h11, 1, 0, 4, 2, 0);
        send_frame(8'h22, 0, 1, 4, 2, 0);
        send_frame(8'h33, 0, 0, 4, 2, 0);
        checks++; if (bus1.count !== 5'd1 || bus1.rd_data !== 8'h33) begin errors++; $display("FAIL droperr_store count=%0d data=%02h want 1/33", bus1.count, bus1.rd_data); end
        checks++; if (bus1.err_count !== 8'd2) begin errors++; $display("FAIL droperr_errcnt got %0d want 2", bus1.err_count); end
        checks++; if (bus1.overflow !== 1'b0) begin errors++; $display("FAIL droperr_ovf got %0b want 0", bus1.overflow); end
        checks++; if (bus0.count !== 5'd3 || bus0.rd_parity_err !== 1'b1) begin errors++; $display("FAIL keeperr_store count=%0d par=%0b want 3/1", bus0.count, bus0.rd_parity_err); end
        repeat (3) pop();
    endtask

    task automatic test_error_flags();
        send_frame(8'h55, 1, 0, 5, 2, 0);
        checks++; if (bus0.rd_data !== 8'h55 || bus0.rd_parity_err !== 1'b1 || bus0.rd_stop_err !== 1'b0)
            begin errors++; $display("FAIL errflag_head data=%02h par=%0b stop=%0b want 55/1/0", bus0.rd_data, bus0.rd_parity_err, bus0.rd_stop_err); end
        checks++; if (bus0.err_count !== 8'(merr[0]) || merr[0] != 3) begin errors++; $display("FAIL errflag_cnt got %0d want 3", bus0.err_count); end
        pop();
        repeat (2) pop();
        checks++; if (bus0.count !== 5'd0 || bus0.empty !== 1'b1) begin errors++; $display("FAIL underflow count=%0d empty=%0b want 0/1", bus0.count, bus0.empty); end
        send_frame(8'hC3, 0, 0, 3, 2, 0);
        checks++; if (bus0.rd_data !== 8'hC3 || bus0.count !== 5'd1) begin errors++; $display("FAIL after_underflow data=%02h count=%0d want c3/1", bus0.rd_data, bus0.count); end
        pop();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) send_frame(8'($urandom), 1'($urandom), 0, 3, 2, 0);
        checks++; if (bus0.count !== 5'd5) begin errors++; $display("FAIL pre_reset count got %0d want 5", bus0.count); end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (bus0.empty !== 1'b1 || bus0.count !== 5'd0) begin errors++; $display("FAIL async_rst empty=%0b count=%0d want 1/0", bus0.empty, bus0.count); end
        checks++; if (bus0.err_count !== 8'd0 || bus0.drop_count !== 8'd0 || bus0.overflow !== 1'b0)
            begin errors++; $display("FAIL async_rst_cnt err=%0d drop=%0d ovf=%0b want 0/0/0", bus0.err_count, bus0.drop_count, bus0.overflow); end
        model_reset();
        rx_data = 8'h77; rx_par = 0; rx_stop = 0; rx_valid = 1'b1;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        repeat (5) tick();
        rx_valid = 1'b0;
        repeat (3) tick();
        checks++; if (bus0.count !== 5'd1 || bus0.rd_data !== 8'h77) begin errors++; $display("FAIL post_rst count=%0d data=%02h want 1/77", bus0.count, bus0.rd_data); end
        pop();
        checks++; if (bus0.empty !== 1'b1) begin errors++; $display("FAIL post_rst_pop empty got %0b want 1", bus0.empty); end
    endtask

    task automatic test_random();
        logic [9:0]      q[$];
        logic [ADDR_W:0] o_cnt;
        logic [7:0]      o_data, o_drop, o_err;
        logic            o_par, o_stop, o_empty, o_full, o_ovf;
        int              hold, gap;
        for (int f = 0; f < 40; f++) begin
            rx_data = 8'($urandom); rx_par = ($urandom % 4 == 0); rx_stop = ($urandom % 4 == 0);
            hold = $urandom_range(3, 6); gap = $urandom_range(1, 4);
            for (int t = 0; t < hold + gap; t++) begin
                rx_valid = (t < hold);
                rd_en = (f < 25) ? ($urandom % 16 == 0) : ($urandom % 2 == 0);
                clr = ($urandom % 8 == 0);
                tick();
                rd_en = 1'b0; clr = 1'b0;
                for (int d = 0; d < 2; d++) begin
                    if (d == 0) begin
                        q = mq0; o_cnt = bus0.count; o_data = bus0.rd_data; o_par = bus0.rd_parity_err;
                        o_stop = bus0.rd_stop_err; o_empty = bus0.empty; o_full = bus0.full;
                        o_ovf = bus0.overflow; o_drop = bus0.drop_count; o_err = bus0.err_count;
                    end else begin
                        q = mq1; o_cnt = bus1.count; o_data = bus1.rd_data; o_par = bus1.rd_parity_err;
                        o_stop = bus1.rd_stop_err; o_empty = bus1.empty; o_full = bus1.full;
                        o_ovf = bus1.overflow; o_drop = bus1.drop_count; o_err = bus1.err_count;
                    end
                    checks++;
                    if (o_cnt !== (ADDR_W+1)'(q.size()) || o_empty !== (q.size() == 0) || o_full !== (q.size() == DEPTH)) begin
                        errors++; $display("FAIL rand_count dut%0d f%0d got %0d/%0b/%0b want %0d", d, f, o_cnt, o_empty, o_full, q.size());
                    end
                    checks++;
                    if (o_ovf !== mov[d] || o_drop !== 8'(mdrop[d]) || o_err !== 8'(merr[d])) begin
                        errors++; $display("FAIL rand_flags dut%0d f%0d ovf=%0b drop=%0d err=%0d want %0b/%0d/%0d",
                                           d, f, o_ovf, o_drop, o_err, mov[d], mdrop[d], merr[d]);
                    end
                    if (q.size() > 0) begin
                        checks++;
                        if ({o_par, o_stop, o_data} !== q[0]) begin
                            errors++; $display("FAIL rand_head dut%0d f%0d got %03h want %03h", d, f, {o_par, o_stop, o_data}, q[0]);
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; rx_data = 8'h00; rx_par = 0; rx_stop = 0; rx_valid = 0; rd_en = 0; clr = 0;
        model_reset();
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_single_frame();
        test_overflow();
        test_full_rdwr();
        test_drop_errored();
        test_error_flags();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
